// File: rtl/infix_to_rpn_pkg.sv
// Shared definitions for the infix-to-RPN converter.
//   - ASCII token constants for the recognised operators and digits
//   - STACK_DEPTH default for the operator stack
//   - state_e: controller states (IDLE, PROC, END, ERR)
//   - act_e:   the single stack action chosen in a PROC cycle
//   - prec(), is_token(): operator classification helpers
package infix_pkg;

  localparam int unsigned STACK_DEPTH = 16;

  localparam logic [7:0] Ch0    = 8'h30;  // '0'
  localparam logic [7:0] Ch9    = 8'h39;  // '9'
  localparam logic [7:0] ChPlus = 8'h2b;  // '+'
  localparam logic [7:0] ChMin  = 8'h2d;  // '-'
  localparam logic [7:0] ChMul  = 8'h2a;  // '*'
  localparam logic [7:0] ChDiv  = 8'h2f;  // '/'
  localparam logic [7:0] ChLpar = 8'h28;  // '('
  localparam logic [7:0] ChRpar = 8'h29;  // ')'
  localparam logic [7:0] ChEq   = 8'h3d;  // '='

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    END  = 2'd2,
    ERR  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    ActNone    = 3'd0,
    ActPopEmit = 3'd1,  // pop top and show it on the sign output
    ActPopDrop = 3'd2,  // pop the matching '(' silently
    ActPush    = 3'd3,
    ActEnd     = 3'd4,
    ActErr     = 3'd5
  } act_e;

  // Binary operator precedence; 0 for anything that is not one.
  function automatic logic [1:0] prec(input logic [7:0] c);
    if ((c == ChMul) || (c == ChDiv)) return 2'd2;
    if ((c == ChPlus) || (c == ChMin)) return 2'd1;
    return 2'd0;
  endfunction

  // Non-digit characters that enter the PROC path.
  function automatic logic is_token(input logic [7:0] c);
    return (c == ChPlus) || (c == ChMin) || (c == ChMul) || (c == ChDiv) ||
           (c == ChLpar) || (c == ChRpar) || (c == ChEq);
  endfunction

endpackage

// File: rtl/infix_to_rpn_if.sv
// Character input handshake and postfix output bus of infix_to_rpn.
//   IN_CHAR/IN_STB/IN_READY : infix character stream (accepted when STB && READY)
//   OUT_NUMBER/NUMBER_STB   : postfix operand and its one-cycle strobe
//   OUT_SIGN/SIGN_STB       : postfix operator and its one-cycle strobe
//   BUSY, ERROR             : status
// master = character source / token sink, slave = the converter.
interface infix_to_rpn_if;
  logic [7:0] IN_CHAR;
  logic       IN_STB;
  logic       IN_READY;
  logic [7:0] OUT_NUMBER;
  logic       NUMBER_STB;
  logic [7:0] OUT_SIGN;
  logic       SIGN_STB;
  logic       BUSY;
  logic       ERROR;

  modport master (
    output IN_CHAR, IN_STB,
    input  IN_READY, OUT_NUMBER, NUMBER_STB, OUT_SIGN, SIGN_STB, BUSY, ERROR
  );

  modport slave (
    input  IN_CHAR, IN_STB,
    output IN_READY, OUT_NUMBER, NUMBER_STB, OUT_SIGN, SIGN_STB, BUSY, ERROR
  );
endinterface

// File: rtl/infix_to_rpn_op_stack.sv
// op_stack: 8-bit LIFO holding pending operators and '('.
//   CLK, RST   : clock, synchronous active-high reset (empties the stack)
//   i_push     : write i_data on top (ignored when full)
//   i_pop      : drop the top entry (ignored when empty)
//   i_clear    : empty the stack
//   o_top      : current top entry (0 when empty)
//   o_full, o_empty : occupancy flags
module op_stack #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic       i_clear,
  input  logic [7:0] i_data,
  output logic [7:0] o_top,
  output logic       o_full,
  output logic       o_empty
);

  localparam int unsigned SpW  = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SpW-1:0] SpOne = SpW'(1);

  logic [7:0]     r_mem [DEPTH];
  logic [SpW-1:0] r_sp;
  logic [IdxW-1:0] w_top_idx;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_full    = (r_sp == SpW'(DEPTH));
  assign o_empty   = (r_sp == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_top_idx = IdxW'(r_sp - SpOne);
  assign o_top     = o_empty ? 8'h00 : r_mem[w_top_idx];

  always_ff @(posedge CLK) begin
    if (RST || i_clear) begin
      r_sp <= '0;
    end else if (w_do_push) begin
      r_sp <= r_sp + SpOne;
    end else if (w_do_pop) begin
      r_sp <= r_sp - SpOne;
    end
  end

  // Storage needs no reset: entries above the pointer are never read.
  always_ff @(posedge CLK) begin
    if (!RST && !i_clear && w_do_push) begin
      r_mem[IdxW'(r_sp)] <= i_data;
    end
  end

endmodule

// File: rtl/infix_to_rpn.sv
// infix_to_rpn: streaming shunting-yard converter from ASCII infix to postfix.
//   CLK, RST : clock, synchronous active-high reset
//   bus_if   : infix_to_rpn_if.slave
//     IN_CHAR/IN_STB/IN_READY  character input, ready only in IDLE without ERROR
//     OUT_NUMBER/NUMBER_STB    operand output (8-bit, value wraps mod 256)
//     OUT_SIGN/SIGN_STB        operator output as ASCII
//     NUMBER_STB & SIGN_STB together with OUT_SIGN='=' mark end of expression
//     BUSY                     state != IDLE
//     ERROR                    sticky syntax / stack-overflow flag, cleared by RST
module infix_to_rpn
  import infix_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = infix_pkg::STACK_DEPTH
) (
  input logic            CLK,
  input logic            RST,
  infix_to_rpn_if.slave  bus_if
);

  state_e     r_state;
  logic [7:0] r_acc;
  logic       r_have_num;
  logic [7:0] r_pending;
  logic       r_error;
  logic [7:0] r_out_number;
  logic       r_number_stb;
  logic [7:0] r_out_sign;
  logic       r_sign_stb;

  logic       w_in_ready;
  logic       w_accept;
  logic       w_is_digit;
  logic [7:0] w_digit;
  act_e       w_act;
  logic [7:0] w_top;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_clear;

  assign w_in_ready = (r_state == IDLE) && !r_error;
  assign w_accept   = bus_if.IN_STB && w_in_ready;
  assign w_is_digit = (bus_if.IN_CHAR >= Ch0) && (bus_if.IN_CHAR <= Ch9);
  assign w_digit    = bus_if.IN_CHAR - Ch0;

  // One stack action per PROC cycle, chosen from the pending token and the top.
  always_comb begin
    w_act = ActNone;
    if (r_state == PROC) begin
      if (r_pending == ChLpar) begin
        w_act = w_full ? ActErr : ActPush;
      end else if (r_pending == ChRpar) begin
        if (w_empty)               w_act = ActErr;
        else if (w_top == ChLpar)  w_act = ActPopDrop;
        else                       w_act = ActPopEmit;
      end else if (r_pending == ChEq) begin
        if (w_empty)               w_act = ActEnd;
        else if (w_top == ChLpar)  w_act = ActErr;
        else                       w_act = ActPopEmit;
      end else begin
        // Left-associative: equal precedence pops too; '(' acts as a barrier.
        if (!w_empty && (w_top != ChLpar) && (prec(w_top) >= prec(r_pending))) begin
          w_act = ActPopEmit;
        end else begin
          w_act = w_full ? ActErr : ActPush;
        end
      end
    end
  end

  assign w_push  = (w_act == ActPush);
  assign w_pop   = (w_act == ActPopEmit) || (w_act == ActPopDrop);
  assign w_clear = (r_state == END);

  op_stack #(
    .DEPTH (STACK_DEPTH)
  ) u_op_stack (
    .CLK     (CLK),
    .RST     (RST),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_clear),
    .i_data  (r_pending),
    .o_top   (w_top),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_acc        <= 8'h00;
      r_have_num   <= 1'b0;
      r_pending    <= 8'h00;
      r_error      <= 1'b0;
      r_out_number <= 8'h00;
      r_number_stb <= 1'b0;
      r_out_sign   <= 8'h00;
      r_sign_stb   <= 1'b0;
    end else begin
      r_number_stb <= 1'b0;
      r_sign_stb   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_is_digit) begin
              r_acc      <= r_acc * 8'd10 + w_digit;
              r_have_num <= 1'b1;
            end else if (is_token(bus_if.IN_CHAR)) begin
              r_pending <= bus_if.IN_CHAR;
              r_state   <= PROC;
              if (r_have_num) begin
                r_out_number <= r_acc;
                r_number_stb <= 1'b1;
              end
              r_acc      <= 8'h00;
              r_have_num <= 1'b0;
            end
          end
        end
        PROC: begin
          case (w_act)
            ActPopEmit: begin
              r_out_sign <= w_top;
              r_sign_stb <= 1'b1;
            end
            ActPopDrop, ActPush: r_state <= IDLE;
            ActEnd: begin
              // Marker is visible while the controller sits in END.
              r_out_sign   <= ChEq;
              r_sign_stb   <= 1'b1;
              r_number_stb <= 1'b1;
              r_state      <= END;
            end
            ActErr: begin
              r_error <= 1'b1;
              r_state <= ERR;
            end
            default: ;
          endcase
        end
        END:  r_state <= IDLE;
        ERR:  r_state <= ERR;
      endcase
    end
  end

  assign bus_if.IN_READY   = w_in_ready;
  assign bus_if.OUT_NUMBER = r_out_number;
  assign bus_if.NUMBER_STB = r_number_stb;
  assign bus_if.OUT_SIGN   = r_out_sign;
  assign bus_if.SIGN_STB   = r_sign_stb;
  assign bus_if.BUSY       = (r_state != IDLE);
  assign bus_if.ERROR      = r_error;

endmodule

// File: tb/tb_infix_to_rpn.sv
// Self-checking bench for infix_to_rpn: directed expressions plus random
// strings checked against a queue-based shunting-yard reference model.
// Token encoding in the record/expect queues:
//   0..255 number, 256+ascii operator, 512 end marker, 1023 illegal strobe pair.
module tb_infix_to_rpn;

  logic CLK;
  logic RST;
  int   n_tests;
  int   n_fail;
  int   rec[$];

  infix_to_rpn_if bus ();

  infix_to_rpn #(
    .STACK_DEPTH (16)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .bus_if (bus)
  );

  always #5 CLK = ~CLK;

  // Record every strobe cycle away from the active edge.
  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.NUMBER_STB && bus.SIGN_STB)
        rec.push_back((bus.OUT_SIGN == 8'h3d) ? 512 : 1023);
      else if (bus.NUMBER_STB)
        rec.push_back(int'(bus.OUT_NUMBER));
      else if (bus.SIGN_STB)
        rec.push_back(256 + int'(bus.OUT_SIGN));
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int prec(input byte c);
    if (c == "*" || c == "/") return 2;
    if (c == "+" || c == "-") return 1;
    return 0;
  endfunction

  function automatic bit is_tok(input byte c);
    return c == "+" || c == "-" || c == "*" || c == "/" || c == "(" || c == ")" || c == "=";
  endfunction

  // Reference: classic shunting-yard over the whole string, stack limit 16.
  function automatic void model(input string s, output int q[$], output bit err);
    int  acc;
    bit  have;
    bit  done;
    byte st[$];
    byte c;
    q = {};
    err = 0;
    acc = 0;
    have = 0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c >= "0" && c <= "9") begin
        acc = (acc * 10 + int'(c - "0")) % 256;
        have = 1;
      end else if (is_tok(c)) begin
        if (have) q.push_back(acc);
        acc = 0;
        have = 0;
        if (c == "(") begin
          if (st.size() >= 16) err = 1;
          else st.push_back(c);
        end else if (c == ")") begin
          done = 0;
          while (!done && !err) begin
            if (st.size() == 0) err = 1;
            else if (st[$] == "(") begin
              void'(st.pop_back());
              done = 1;
            end else q.push_back(256 + int'(st.pop_back()));
          end
        end else if (c == "=") begin
          while (st.size() > 0 && !err) begin
            if (st[$] == "(") err = 1;
            else q.push_back(256 + int'(st.pop_back()));
          end
          if (!err) q.push_back(512);
        end else begin
          while (st.size() > 0 && st[$] != "(" && prec(st[$]) >= prec(c))
            q.push_back(256 + int'(st.pop_back()));
          if (st.size() >= 16) err = 1;
          else st.push_back(c);
        end
        if (err) return;
      end
    end
  endfunction

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    rec.delete();
  endtask

  // Present one character; characters after an error are not offered.
  task automatic send(input byte c);
    int n;
    n = 0;
    while (!bus.IN_READY && !bus.ERROR && n < 200) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (bus.ERROR) return;
    if (!bus.IN_READY) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    bus.IN_CHAR = c;
    bus.IN_STB  = 1'b1;
    @(posedge CLK);
    #1;
    bus.IN_STB  = 1'b0;
  endtask

  task automatic run_check(input string tag, input string s, input int exp[$],
                           input bit exp_err);
    rec.delete();
    for (int i = 0; i < s.len(); i++) send(s[i]);
    repeat (40) @(posedge CLK);
    #1;
    chk({tag, "_len"}, rec.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rec.size(); i++)
      chk($sformatf("%s_tok%0d", tag, i), rec[i], exp[i]);
    chk({tag, "_err"}, int'(bus.ERROR), int'(exp_err));
    chk({tag, "_ready"}, int'(bus.IN_READY), int'(!exp_err));
  endtask

  initial begin
    int    exp[$];
    bit    e;
    string s;
    string alpha;
    byte   c;
    int    len;

    n_tests = 0;
    n_fail  = 0;
    CLK = 1'b0;
    RST = 1'b1;
    bus.IN_CHAR = 8'h00;
    bus.IN_STB  = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    chk("rst_ready", int'(bus.IN_READY), 1);
    chk("rst_busy", int'(bus.BUSY), 0);
    chk("rst_error", int'(bus.ERROR), 0);
    chk("rst_nstb", int'(bus.NUMBER_STB), 0);
    chk("rst_sstb", int'(bus.SIGN_STB), 0);
    chk("rst_num", int'(bus.OUT_NUMBER), 0);
    chk("rst_sign", int'(bus.OUT_SIGN), 0);

    exp = '{3, 4, 2, 298, 299, 512};
    run_check("prec", "3+4*2=", exp, 0);
    chk("hold_sign", int'(bus.OUT_SIGN), 61);
    chk("idle_busy", int'(bus.BUSY), 0);

    exp = '{1, 2, 299, 3, 298, 512};
    run_check("paren", "(1+2)*3=", exp, 0);

    exp = '{12, 5, 301, 1, 301, 512};
    run_check("leftassoc", "12-5-1=", exp, 0);

    exp = '{44, 512};
    run_check("wrap", "300=", exp, 0);

    exp = '{7, 3, 303, 512};
    run_check("ignored", "7 x/3=", exp, 0);

    exp = '{1, 2, 299};
    run_check("unbal", "1+2)=", exp, 1);
    chk("err_busy", int'(bus.BUSY), 1);
    do_reset();

    exp = '{};
    run_check("deep16", "((((((((((((((((", exp, 0);
    run_check("deep17", "(", exp, 1);
    do_reset();

    // Reset while the '(' of "9*(" is being processed.
    send("9");
    send("*");
    send("(");
    chk("proc_busy", int'(bus.BUSY), 1);
    do_reset();
    repeat (10) @(posedge CLK);
    #1;
    chk("midrst_strobes", rec.size(), 0);
    chk("midrst_ready", int'(bus.IN_READY), 1);
    chk("midrst_busy", int'(bus.BUSY), 0);
    chk("midrst_num", int'(bus.OUT_NUMBER), 0);
    chk("midrst_sign", int'(bus.OUT_SIGN), 0);
    exp = '{5, 512};
    run_check("after_rst", "5=", exp, 0);

    alpha = "0123456789012345+-*/+-*/()( x";
    for (int k = 0; k < 40; k++) begin
      s = "";
      len = $urandom_range(1, 14);
      for (int j = 0; j < len; j++) begin
        c = alpha[$urandom_range(0, alpha.len() - 1)];
        s = $sformatf("%s%c", s, c);
      end
      s = $sformatf("%s=", s);
      model(s, exp, e);
      run_check($sformatf("rnd%0d", k), s, exp, e);
      if (e) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
